// File: rtl/pipeexe_mc_if.sv
// ID/EX -> EX -> MEM handshake bundle for the multi-cycle execute stage.
// master drives the instruction and MEM-ready; slave is the execute stage.
interface pipeexe_mc_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RW   = 5
);
  logic            ein_valid;
  logic [3:0]      ealuc;
  logic [1:0]      emdop;
  logic            ealuimm;
  logic            eshift;
  logic            ejal;
  logic [XLEN-1:0] ea;
  logic [XLEN-1:0] eb;
  logic [XLEN-1:0] eimm;
  logic [XLEN-1:0] epc4;
  logic [RW-1:0]   ern0;
  logic            mready;
  logic            estall;
  logic            mvalid;
  logic [RW-1:0]   mrn;
  logic [XLEN-1:0] malu;

  modport master (
    output ein_valid, ealuc, emdop, ealuimm, eshift, ejal,
           ea, eb, eimm, epc4, ern0, mready,
    input  estall, mvalid, mrn, malu
  );

  modport slave (
    input  ein_valid, ealuc, emdop, ealuimm, eshift, ejal,
           ea, eb, eimm, epc4, ern0, mready,
    output estall, mvalid, mrn, malu
  );
endinterface

// File: rtl/pipeexe_mc.sv
// Execute stage: single-cycle ALU/shift/jal plus iterative unsigned mul/divu/remu,
// with a registered EX/MEM output under a valid/ready handshake.
module pipeexe_mc #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RW   = 5,
  parameter int unsigned CW   = 6
) (
  input logic         clock,
  input logic         reset,
  pipeexe_mc_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] sa;
  logic [XLEN-1:0] sb;
  logic [1:0]      mop;
  logic [RW-1:0]   mrd;

  logic            mvalid_r;
  logic [RW-1:0]   mrn_r;
  logic [XLEN-1:0] malu_r;

  logic            estall;
  logic            freeo;
  logic            accept;
  logic            multi_sel;
  logic            mc_done;
  logic            load;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [4:0]      shamt;
  logic [RW-1:0]   dest;
  logic [XLEN-1:0] alu;
  logic [XLEN-1:0] single_res;
  logic [XLEN-1:0] mc_res;
  logic [XLEN-1:0] acc_n;
  logic [XLEN-1:0] sa_n;
  logic [XLEN-1:0] sb_n;
  logic [XLEN:0]   rs;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] src_acc;
  logic [XLEN-1:0] src_sa;

  assign freeo     = ~mvalid_r | bus.mready;
  assign estall    = (state != S_IDLE) | (mvalid_r & ~bus.mready);
  assign accept    = bus.ein_valid & ~estall;
  assign multi_sel = ~bus.ejal & (bus.emdop != 2'b00);

  assign opa   = bus.eshift ? {{(XLEN-5){1'b0}}, bus.eimm[10:6]} : bus.ea;
  assign opb   = bus.ealuimm ? bus.eimm : bus.eb;
  assign shamt = opa[4:0];
  assign dest  = bus.ern0 | {RW{bus.ejal}};

  always_comb begin
    alu = '0;
    case (bus.ealuc[2:0])
      3'b000: alu = opa + opb;
      3'b100: alu = opa - opb;
      3'b001: alu = opa & opb;
      3'b101: alu = opa | opb;
      3'b010: alu = opa ^ opb;
      3'b110: alu = opb << (XLEN/2);
      3'b011: alu = opb << shamt;
      3'b111: alu = bus.ealuc[3] ? $unsigned($signed(opb) >>> shamt) : (opb >> shamt);
      default: alu = '0;
    endcase
  end

  assign single_res = bus.ejal ? (bus.epc4 + XLEN'(4)) : alu;

  // One iteration: mul adds the shifted multiplicand; div is a restoring step
  // whose remainder lives in acc and whose quotient shifts into sa.
  always_comb begin
    acc_n = acc;
    sa_n  = sa;
    sb_n  = sb;
    rs    = '0;
    trial = '0;
    if (mop == 2'b01) begin
      acc_n = acc + (sa[0] ? sb : '0);
      sa_n  = sa >> 1;
      sb_n  = sb << 1;
    end else begin
      rs    = {acc, sa[XLEN-1]};
      trial = rs - {1'b0, sb};
      acc_n = trial[XLEN] ? rs[XLEN-1:0] : trial[XLEN-1:0];
      sa_n  = {sa[XLEN-2:0], ~trial[XLEN]};
    end
  end

  // The last BUSY step is folded into the write so the result lands
  // without an extra cycle; HOLD reads the already-final registers.
  assign src_acc = (state == S_BUSY) ? acc_n : acc;
  assign src_sa  = (state == S_BUSY) ? sa_n  : sa;
  assign mc_res  = (mop == 2'b10) ? src_sa : src_acc;

  assign mc_done = freeo & (((state == S_BUSY) & (cnt == CW'(1))) | (state == S_HOLD));
  assign load    = (accept & ~multi_sel) | mc_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      sa       <= '0;
      sb       <= '0;
      mop      <= '0;
      mrd      <= '0;
      mvalid_r <= 1'b0;
      mrn_r    <= '0;
      malu_r   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && multi_sel) begin
            state <= S_BUSY;
            cnt   <= CW'(XLEN);
            acc   <= '0;
            sa    <= opa;
            sb    <= opb;
            mop   <= bus.emdop;
            mrd   <= dest;
          end
        end
        S_BUSY: begin
          acc <= acc_n;
          sa  <= sa_n;
          sb  <= sb_n;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= freeo ? S_IDLE : S_HOLD;
          end
        end
        S_HOLD: begin
          if (freeo) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (load) begin
        mvalid_r <= 1'b1;
        malu_r   <= mc_done ? mc_res : single_res;
        mrn_r    <= mc_done ? mrd : dest;
      end else if (bus.mready) begin
        mvalid_r <= 1'b0;
      end
    end
  end

  assign bus.estall = estall;
  assign bus.mvalid = mvalid_r;
  assign bus.mrn    = mrn_r;
  assign bus.malu   = malu_r;

endmodule

// File: tb/tb_pipeexe_mc.sv
// Bench for pipeexe_mc: directed vector table, handshake/reset corner sequences,
// an XLEN=16 instance, and randomized traffic against a behavioural scoreboard.
module tb_pipeexe_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeexe_mc_if #(.XLEN(32), .RW(5)) b32 ();
  pipeexe_mc_if #(.XLEN(16), .RW(5)) b16 ();

  pipeexe_mc #(.XLEN(32), .RW(5), .CW(6)) dut32 (.clock(clk), .reset(rst), .bus(b32.slave));
  pipeexe_mc #(.XLEN(16), .RW(5), .CW(5)) dut16 (.clock(clk), .reset(rst), .bus(b16.slave));

  typedef struct {
    logic [3:0]  aluc;
    logic [1:0]  md;
    logic        imm;
    logic        sh;
    logic        jal;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic [31:0] pc4;
    logic [4:0]  rn;
    logic [31:0] ev;
    logic [4:0]  er;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] qv[$];
  logic [4:0]  qr[$];
  int          busy = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [1:0] md, input logic imm,
                              input logic sh, input logic jal, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] im, input logic [31:0] pc4,
                              input logic [4:0] rn, input logic [31:0] ev, input logic [4:0] er);
    vec_t v;
    v.aluc = c; v.md = md; v.imm = imm; v.sh = sh; v.jal = jal;
    v.a = a; v.b = b; v.im = im; v.pc4 = pc4; v.rn = rn; v.ev = ev; v.er = er;
    return v;
  endfunction

  // Behavioural result of one instruction, straight from the operation rules.
  function automatic logic [31:0] ref32(input logic [3:0] c, input logic [1:0] md,
                                        input logic imm, input logic sh, input logic jal,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] im, input logic [31:0] pc4);
    logic [31:0] x;
    logic [31:0] y;
    int unsigned s;
    x = sh ? {27'd0, im[10:6]} : a;
    y = imm ? im : b;
    s = 32'(x[4:0]);
    if (jal) return pc4 + 32'd4;
    if (md == 2'd1) return x * y;
    if (md == 2'd2) return (y == 0) ? 32'hFFFF_FFFF : x / y;
    if (md == 2'd3) return (y == 0) ? x : x % y;
    case (c)
      4'b0011: return y << s;
      4'b0111: return y >> s;
      4'b1111: return $unsigned($signed(y) >>> s);
      default: ;
    endcase
    case (c[2:0])
      3'b000: return x + y;
      3'b100: return x - y;
      3'b001: return x & y;
      3'b101: return x | y;
      3'b010: return x ^ y;
      3'b110: return y << 16;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_in(input vec_t v);
    b32.ealuc = v.aluc; b32.emdop = v.md; b32.ealuimm = v.imm; b32.eshift = v.sh;
    b32.ejal = v.jal; b32.ea = v.a; b32.eb = v.b; b32.eimm = v.im; b32.epc4 = v.pc4;
    b32.ern0 = v.rn;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int  lat;
    int  stl;
    bit  multi;
    multi = !v.jal && (v.md != 2'b00);
    @(negedge clk);
    set_in(v);
    b32.ein_valid = 1'b1;
    b32.mready    = 1'b1;
    #1 chk({nm, ".idle"}, 32'(b32.estall), 32'd0);
    @(negedge clk);
    b32.ein_valid = 1'b0;
    #1;
    lat = 1;
    stl = 0;
    while (!b32.mvalid && lat < 100) begin
      if (b32.estall) stl++;
      @(negedge clk);
      #1;
      lat++;
    end
    chk({nm, ".mvalid"}, 32'(b32.mvalid), 32'd1);
    chk({nm, ".malu"}, b32.malu, v.ev);
    chk({nm, ".mrn"}, 32'(b32.mrn), 32'(v.er));
    chk({nm, ".lat"}, 32'(lat), multi ? 32'd33 : 32'd1);
    chk({nm, ".stall"}, 32'(stl), multi ? 32'd32 : 32'd0);
    chk({nm, ".estall_end"}, 32'(b32.estall), 32'd0);
  endtask

  task automatic run16(input logic [1:0] md, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ev, input string nm);
    int lat;
    int stl;
    @(negedge clk);
    b16.emdop = md; b16.ea = a; b16.eb = b; b16.ern0 = 5'd9;
    b16.ein_valid = 1'b1;
    b16.mready    = 1'b1;
    @(negedge clk);
    b16.ein_valid = 1'b0;
    #1;
    lat = 1;
    stl = 0;
    while (!b16.mvalid && lat < 60) begin
      if (b16.estall) stl++;
      @(negedge clk);
      #1;
      lat++;
    end
    chk({nm, ".malu"}, 32'(b16.malu), 32'(ev));
    chk({nm, ".mrn"}, 32'(b16.mrn), 32'd9);
    chk({nm, ".lat"}, 32'(lat), 32'd17);
    chk({nm, ".stall"}, 32'(stl), 32'd16);
  endtask

  // One cycle of scoreboarded traffic; with newops=0 only drains.
  task automatic step(input bit newops);
    logic [3:0]  c;
    logic [1:0]  md;
    logic        mv_m;
    logic        acc;
    logic [31:0] eres;
    @(negedge clk);
    if (newops) begin
      c = 4'($urandom);
      if (c[1:0] == 2'b11 && c != 4'b0111 && c != 4'b1111) c = 4'b0011;
      md = ($urandom_range(0, 9) < 2) ? 2'($urandom_range(1, 3)) : 2'b00;
      b32.ealuc = c; b32.emdop = md;
      b32.ealuimm = 1'($urandom); b32.eshift = 1'($urandom);
      b32.ejal = ($urandom_range(0, 9) == 0);
      b32.ea = $urandom;
      b32.eb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      b32.eimm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2047)) : $urandom;
      b32.epc4 = $urandom;
      b32.ern0 = 5'($urandom);
      b32.ein_valid = ($urandom_range(0, 3) != 0);
      b32.mready    = ($urandom_range(0, 3) != 0);
    end else begin
      b32.ein_valid = 1'b0;
      b32.mready    = 1'b1;
    end
    #1;
    mv_m = (qv.size() > 0) && (busy == 0);
    chk("rnd.mvalid", 32'(b32.mvalid), 32'(mv_m));
    chk("rnd.estall", 32'(b32.estall), 32'((busy > 0) || (mv_m && !b32.mready)));
    if (b32.mvalid && b32.mready && qv.size() > 0) begin
      chk("rnd.malu", b32.malu, qv.pop_front());
      chk("rnd.mrn", 32'(b32.mrn), 32'(qr.pop_front()));
    end
    acc = b32.ein_valid && !b32.estall;
    if (busy > 0) busy--;
    if (acc) begin
      eres = ref32(b32.ealuc, b32.emdop, b32.ealuimm, b32.eshift, b32.ejal,
                   b32.ea, b32.eb, b32.eimm, b32.epc4);
      qv.push_back(eres);
      qr.push_back(b32.ejal ? 5'd31 : b32.ern0);
      if (!b32.ejal && b32.emdop != 2'b00) busy = 32;
    end
  endtask

  vec_t tv[20];

  initial begin
    int seen;

    tv[0]  = mk(4'b0000, 2'b00, 0, 0, 0, 32'd5, 32'd7, 0, 0, 5'd3, 32'd12, 5'd3);
    tv[1]  = mk(4'b0000, 2'b00, 0, 0, 1, 0, 0, 0, 32'h100, 5'd0, 32'h104, 5'd31);
    tv[2]  = mk(4'b0000, 2'b01, 0, 0, 1, 0, 0, 0, 32'h100, 5'd0, 32'h104, 5'd31);
    tv[3]  = mk(4'b0100, 2'b00, 0, 0, 0, 32'd5, 32'd7, 0, 0, 5'd4, 32'hFFFF_FFFE, 5'd4);
    tv[4]  = mk(4'b0001, 2'b00, 0, 0, 0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 5'd5, 32'h00F0_000F, 5'd5);
    tv[5]  = mk(4'b0101, 2'b00, 0, 0, 0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 5'd6, 32'hFFF0_0FFF, 5'd6);
    tv[6]  = mk(4'b0010, 2'b00, 0, 0, 0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 5'd7, 32'hFF00_0FF0, 5'd7);
    tv[7]  = mk(4'b1110, 2'b00, 0, 0, 0, 32'd9, 32'h0000_1234, 0, 0, 5'd8, 32'h1234_0000, 5'd8);
    tv[8]  = mk(4'b0011, 2'b00, 0, 0, 0, 32'd4, 32'h8000_0001, 0, 0, 5'd9, 32'h0000_0010, 5'd9);
    tv[9]  = mk(4'b0111, 2'b00, 0, 0, 0, 32'd4, 32'h8000_0000, 0, 0, 5'd10, 32'h0800_0000, 5'd10);
    tv[10] = mk(4'b1111, 2'b00, 0, 0, 0, 32'd4, 32'h8000_0000, 0, 0, 5'd11, 32'hF800_0000, 5'd11);
    tv[11] = mk(4'b1000, 2'b00, 1, 0, 0, 32'd10, 32'd77, 32'hFFFF_FFFF, 0, 5'd12, 32'd9, 5'd12);
    tv[12] = mk(4'b0011, 2'b00, 0, 1, 0, 32'hFFFF_FFE0, 32'd1, 32'h100, 0, 5'd13, 32'h10, 5'd13);
    tv[13] = mk(4'b0000, 2'b01, 0, 0, 0, 32'hFFFF_FFFF, 32'd3, 0, 0, 5'd14, 32'hFFFF_FFFD, 5'd14);
    tv[14] = mk(4'b0000, 2'b10, 0, 0, 0, 32'd100, 32'd7, 0, 0, 5'd15, 32'd14, 5'd15);
    tv[15] = mk(4'b0000, 2'b11, 0, 0, 0, 32'd100, 32'd7, 0, 0, 5'd16, 32'd2, 5'd16);
    tv[16] = mk(4'b0000, 2'b10, 0, 0, 0, 32'd9, 32'd0, 0, 0, 5'd17, 32'hFFFF_FFFF, 5'd17);
    tv[17] = mk(4'b0000, 2'b11, 0, 0, 0, 32'd9, 32'd0, 0, 0, 5'd18, 32'd9, 5'd18);
    tv[18] = mk(4'b0000, 2'b00, 0, 0, 0, 32'hFFFF_FFFF, 32'd2, 0, 0, 5'd19, 32'd1, 5'd19);
    tv[19] = mk(4'b0000, 2'b01, 1, 0, 0, 32'h1234, 32'd5, 32'h10, 0, 5'd20, 32'h0001_2340, 5'd20);

    set_in(tv[0]);
    b32.ein_valid = 1'b0; b32.mready = 1'b1;
    b16.ein_valid = 1'b0; b16.mready = 1'b1; b16.ealuc = '0; b16.emdop = '0;
    b16.ealuimm = 1'b0; b16.eshift = 1'b0; b16.ejal = 1'b0; b16.ea = '0; b16.eb = '0;
    b16.eimm = '0; b16.epc4 = '0; b16.ern0 = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.mvalid", 32'(b32.mvalid), 32'd0);
    chk("reset.malu", b32.malu, 32'd0);
    chk("reset.mrn", 32'(b32.mrn), 32'd0);
    chk("reset.estall", 32'(b32.estall), 32'd0);

    for (int i = 0; i < 20; i++) run_vec(tv[i], $sformatf("vec%0d", i));

    // Back-pressure: first result held for three cycles, second accepted on release.
    @(negedge clk);
    set_in(mk(4'b0000, 2'b00, 0, 0, 0, 32'd1, 32'd1, 0, 0, 5'd1, 0, 0));
    b32.ein_valid = 1'b1; b32.mready = 1'b1;
    @(negedge clk);
    set_in(mk(4'b0000, 2'b00, 0, 0, 0, 32'd2, 32'd3, 0, 0, 5'd2, 0, 0));
    b32.mready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("bp.estall", 32'(b32.estall), 32'd1);
      chk("bp.held_malu", b32.malu, 32'd2);
      chk("bp.held_mrn", 32'(b32.mrn), 32'd1);
    end
    @(negedge clk);
    b32.mready = 1'b1;
    #1;
    chk("bp.release_estall", 32'(b32.estall), 32'd0);
    chk("bp.release_malu", b32.malu, 32'd2);
    @(negedge clk);
    b32.ein_valid = 1'b0;
    #1;
    chk("bp.second_mvalid", 32'(b32.mvalid), 32'd1);
    chk("bp.second_malu", b32.malu, 32'd5);
    chk("bp.second_mrn", 32'(b32.mrn), 32'd2);
    @(negedge clk);
    #1 chk("bp.no_dup", 32'(b32.mvalid), 32'd0);

    // Reset during BUSY cycle 10 aborts the multiply.
    @(negedge clk);
    set_in(mk(4'b0000, 2'b01, 0, 0, 0, 32'd7, 32'd9, 0, 0, 5'd6, 0, 0));
    b32.ein_valid = 1'b1; b32.mready = 1'b1;
    @(negedge clk);
    b32.ein_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1 chk("abort.busy_before", 32'(b32.estall), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort.mvalid", 32'(b32.mvalid), 32'd0);
    chk("abort.estall", 32'(b32.estall), 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (b32.mvalid || b32.estall) seen++;
    end
    chk("abort.no_late_result", 32'(seen), 32'd0);

    run16(2'b01, 16'd300, 16'd300, 16'h5F90, "x16.mul");
    run16(2'b10, 16'hFFFF, 16'h0010, 16'h0FFF, "x16.divu");
    run16(2'b11, 16'hFFFF, 16'h0010, 16'h000F, "x16.remu");

    @(negedge clk);
    b32.ein_valid = 1'b0; b32.mready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 700; k++) step(1'b1);
    for (int k = 0; k < 80 && (qv.size() > 0 || busy > 0); k++) step(1'b0);
    chk("drain.empty", 32'(qv.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
